// File: rtl/multicycle_mips_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, opcode/funct
// constants, ALU operation codes and the ALU evaluation function.
package multicycle_mips_pkg;

   localparam int XLEN   = 32;
   localparam int RIDX_W = 5;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, HALT, MULT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_NOR
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [XLEN-1:0] HALT_INSN = 32'hFFFF_FFFF;

   // Shifts act on b (the rt operand) by sh, matching the MIPS sll/srl form.
   function automatic logic [XLEN-1:0] alu(input alu_op_t op, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b, input logic [4:0] sh);
      logic [XLEN-1:0] y;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLL: y = b << sh;
         ALU_SRL: y = b >> sh;
         ALU_NOR: y = ~(a | b);
         default: y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: NREGS x 32, two asynchronous read ports, one synchronous
// write port; index 0 and indices >= NREGS read as zero and ignore writes.
module mips_regfile
   import multicycle_mips_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RIDX_W-1:0] raddr1,
   input  logic [RIDX_W-1:0] raddr2,
   input  logic              we,
   input  logic [RIDX_W-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2
);

   logic [XLEN-1:0] regs [1:NREGS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         for (int i = 1; i < NREGS; i++)
            if (waddr == RIDX_W'(i)) regs[i] <= wdata;
      end
   end

   // Decoded read: any index without backing storage falls through to zero.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (raddr1 == RIDX_W'(i)) rdata1 = regs[i];
         if (raddr2 == RIDX_W'(i)) rdata2 = regs[i];
      end
   end

endmodule

// File: rtl/multicycle_mips.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with a simple
// data-memory handshake. Define MIPS_MULT_EN to add mult/mflo/mfhi and HI/LO.
module multicycle_mips
   import multicycle_mips_pkg::*;
#(
   parameter int          DMEM_AW  = 7,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        IR_addr,
   input  logic [31:0]        IR,
   input  logic [31:0]        ReadDataMem,
   input  logic               mem_rdy,
   output logic               CEN,
   output logic               WEN,
   output logic               OEN,
   output logic [DMEM_AW-1:0] A,
   output logic [31:0]        Data2Mem,
   output logic               halted,
   output state_t             dbg_state
);

   state_t            state;
   logic [31:0]       pc, ir, ra, rb, imm, alu_out;
   logic [4:0]        wr_addr;
   logic [31:0]       alu_b, alu_y, rd1, rd2, rf_wdata;
   alu_op_t           alu_op;
   logic              rf_we, br_taken;
   logic [4:0]        rf_waddr;

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, shamt;
   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];

`ifdef MIPS_MULT_EN
   logic [31:0] hi, lo, mplier;
   logic [63:0] mcand, acc, acc_next;
   logic [4:0]  mcnt;
   logic        mneg;
   assign acc_next = mplier[0] ? acc + mcand : acc;
`endif

   assign IR_addr   = pc;
   assign dbg_state = state;

   // jal writes the return address (pc already advanced) during EXEC.
   assign rf_we    = (state == WB) || (state == EXEC && op == OP_JAL);
   assign rf_waddr = (state == WB) ? wr_addr : 5'd31;
   assign rf_wdata = (state == WB) ? alu_out : pc;

   mips_regfile #(.NREGS(NREGS)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (rs),
      .raddr2 (rt),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .rdata1 (rd1),
      .rdata2 (rd2)
   );

   // andi/ori use the zero-extended immediate; everything else the signed one.
   always_comb begin
      alu_op = ALU_ADD;
      alu_b  = imm;
      case (op)
         OP_RTYPE: begin
            alu_b = rb;
            case (funct)
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_NOR:  alu_op = ALU_NOR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLL:  alu_op = ALU_SLL;
               FN_SRL:  alu_op = ALU_SRL;
               default: alu_op = ALU_ADD;
            endcase
         end
         OP_SLTI: alu_op = ALU_SLT;
         OP_ANDI: begin
            alu_op = ALU_AND;
            alu_b  = {16'h0000, imm[15:0]};
         end
         OP_ORI: begin
            alu_op = ALU_OR;
            alu_b  = {16'h0000, imm[15:0]};
         end
         default: ;
      endcase
   end

   assign alu_y    = alu(alu_op, ra, alu_b, shamt);
   assign br_taken = (op == OP_BEQ) ? (ra == rb) : (ra != rb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         ir       <= '0;
         ra       <= '0;
         rb       <= '0;
         imm      <= '0;
         alu_out  <= '0;
         wr_addr  <= '0;
         CEN      <= 1'b1;
         WEN      <= 1'b1;
         OEN      <= 1'b1;
         A        <= '0;
         Data2Mem <= '0;
         halted   <= 1'b0;
`ifdef MIPS_MULT_EN
         hi       <= '0;
         lo       <= '0;
         mplier   <= '0;
         mcand    <= '0;
         acc      <= '0;
         mcnt     <= '0;
         mneg     <= 1'b0;
`endif
      end else begin
         case (state)
            FETCH: begin
               ir    <= IR;
               pc    <= pc + 32'd4;
               state <= DECODE;
            end
            DECODE: begin
               if (ir == HALT_INSN) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  ra    <= rd1;
                  rb    <= rd2;
                  imm   <= {{16{ir[15]}}, ir[15:0]};
                  state <= EXEC;
               end
            end
            EXEC: begin
               state <= FETCH;
               case (op)
                  OP_RTYPE: begin
                     case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL: begin
                           alu_out <= alu_y;
                           wr_addr <= rd;
                           state   <= WB;
                        end
                        FN_JR: pc <= ra;
`ifdef MIPS_MULT_EN
                        FN_MULT: begin
                           mcand  <= {32'h0, ra[31] ? -ra : ra};
                           mplier <= rb[31] ? -rb : rb;
                           acc    <= '0;
                           mcnt   <= '0;
                           mneg   <= ra[31] ^ rb[31];
                           state  <= MULT;
                        end
                        FN_MFHI: begin
                           alu_out <= hi;
                           wr_addr <= rd;
                           state   <= WB;
                        end
                        FN_MFLO: begin
                           alu_out <= lo;
                           wr_addr <= rd;
                           state   <= WB;
                        end
`endif
                        default: ;
                     endcase
                  end
                  OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                     alu_out <= alu_y;
                     wr_addr <= rt;
                     state   <= WB;
                  end
                  OP_LW, OP_SW: begin
                     A        <= alu_y[DMEM_AW+1:2];
                     Data2Mem <= rb;
                     CEN      <= 1'b0;
                     WEN      <= (op != OP_SW);
                     OEN      <= (op != OP_LW);
                     wr_addr  <= rt;
                     state    <= MEM;
                  end
                  OP_BEQ, OP_BNE: if (br_taken) pc <= pc + {imm[29:0], 2'b00};
                  OP_J, OP_JAL:   pc <= {pc[31:28], ir[25:0], 2'b00};
                  default: ;
               endcase
            end
            MEM: begin
               // Bus signals stay frozen until the memory signals completion.
               if (mem_rdy) begin
                  CEN <= 1'b1;
                  WEN <= 1'b1;
                  OEN <= 1'b1;
                  if (!WEN) begin
                     state <= FETCH;
                  end else begin
                     alu_out <= ReadDataMem;
                     state   <= WB;
                  end
               end
            end
            WB:   state <= FETCH;
            HALT: state <= HALT;
`ifdef MIPS_MULT_EN
            MULT: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               mcnt   <= mcnt + 5'd1;
               if (mcnt == 5'd31) begin
                  {hi, lo} <= mneg ? -acc_next : acc_next;
                  state    <= FETCH;
               end
            end
`endif
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: bench-side instruction/data memories,
// a queue of expected bus transactions, and cycle-latency checks.
module tb_multicycle_mips;
   import multicycle_mips_pkg::*;

   localparam int AW = 7;
   localparam int W  = 2 + AW + 32;

   localparam int T_ADDI = 8, T_SLTI = 10, T_ANDI = 12, T_ORI = 13;
   localparam int T_LW = 35, T_SW = 43, T_BEQ = 4, T_BNE = 5, T_JAL = 3;
   localparam int F_ADD = 32, F_SUB = 34, F_AND = 36, F_OR = 37, F_NOR = 39;
   localparam int F_SLT = 42, F_SLL = 0, F_SRL = 2, F_JR = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_rdy = 1'b1;
   logic [31:0]   IR_addr, IR, ReadDataMem, Data2Mem;
   logic          CEN, WEN, OEN, halted;
   logic [AW-1:0] A;
   state_t        dbg_state;

   logic [31:0] imem [0:127];
   logic [31:0] dmem [0:127];
   assign IR          = imem[IR_addr[8:2]];
   assign ReadDataMem = dmem[A];

   always #5 clk = ~clk;

   multicycle_mips #(.DMEM_AW(AW), .RESET_PC(32'h0), .NREGS(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .IR_addr     (IR_addr),
      .IR          (IR),
      .ReadDataMem (ReadDataMem),
      .mem_rdy     (mem_rdy),
      .CEN         (CEN),
      .WEN         (WEN),
      .OEN         (OEN),
      .A           (A),
      .Data2Mem    (Data2Mem),
      .halted      (halted),
      .dbg_state   (dbg_state)
   );

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   int          st_reg [13] = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 0};
   logic [31:0] st_val [13] = '{32'h1, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFFF, 32'h50, 32'hF,
                                32'h8, 32'hF5, 32'hFF, 32'h50, 32'h5F, 32'h1, 32'h0};

   function automatic logic [31:0] r_i(int fn, int rs, int rt, int rd, int sh);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction
   function automatic logic [31:0] i_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [W-1:0] exp_st(int addr, logic [31:0] d);
      return {1'b0, 1'b1, AW'(addr), d};
   endfunction
   function automatic logic [W-1:0] exp_ld(int addr);
      return {1'b1, 1'b0, AW'(addr), 32'h0};
   endfunction
   function automatic logic [W-1:0] pack_bus();
      return {WEN, OEN, A, (WEN ? 32'h0 : Data2Mem)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pc", IR_addr, 32'h0);
      check("rst_bus", {CEN, WEN, OEN, halted}, 4'b1110);
      check("rst_a_data", {A, Data2Mem}, '0);
      check("rst_state", dbg_state, FETCH);
      rst_n = 1'b1;
   endtask

   task automatic wait_pc(input logic [31:0] pc, output int n);
      n = 0;
      while (IR_addr !== pc && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_cen(output int lat, output logic [W-1:0] exp);
      lat = 0;
      while (CEN !== 1'b0 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("mem_enable", CEN, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("mem_txn", pack_bus(), exp);
   endtask

   task automatic mem_access(input int waits, input int exp_lat);
      int lat;
      logic [W-1:0] exp;
      wait_cen(lat, exp);
      check("mem_latency", lat, exp_lat);
      if (waits > 0) begin
         mem_rdy = 1'b0;
         for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("mem_hold", {CEN, pack_bus()}, {1'b0, exp});
         end
         mem_rdy = 1'b1;
      end
      @(negedge clk);
      check("mem_idle", {CEN, WEN, OEN}, 3'b111);
   endtask

   initial begin
      int n;
      int lat;
      logic [W-1:0] exp;

      for (int i = 0; i < 128; i++) begin
         imem[i] = 32'hFC00_0000;
         dmem[i] = 32'h0;
      end
      dmem[1]  = 32'h1234;
      dmem[16] = 32'hCAFE;

      // Program A: ALU, stalled store, load, jal/jr, self-branch.
      imem[0]  = i_i(T_ADDI, 0, 1, 5);
      imem[1]  = r_i(F_ADD, 1, 1, 2, 0);
      imem[2]  = i_i(T_SW, 0, 2, 4);
      imem[3]  = i_i(T_LW, 0, 3, 4);
      imem[4]  = {6'(T_JAL), 26'h40};
      imem[64] = i_i(T_SW, 0, 31, 8);
      imem[65] = r_i(F_JR, 31, 0, 0, 0);
      imem[5]  = i_i(T_SW, 0, 3, 12);
      imem[6]  = i_i(T_BEQ, 3, 3, -1);
      exp_q.push_back(exp_st(1, 32'd10));
      exp_q.push_back(exp_ld(1));
      exp_q.push_back(exp_st(2, 32'h14));
      exp_q.push_back(exp_st(3, 32'h1234));

      do_reset();
      check("release_pc", IR_addr, 32'h0);
      check("release_bus", {CEN, WEN, OEN}, 3'b111);
      repeat (8) @(negedge clk);
      check("pc_after_8", IR_addr, 32'h8);
      check("state_after_8", dbg_state, FETCH);
      mem_access(2, 3);
      check("pc_after_sw", IR_addr, 32'hC);
      mem_access(0, 3);
      wait_pc(32'h14, n);
      check("lw_tail_cycles", n, 2);
      wait_pc(32'h100, n);
      check("jal_target_cycles", n, 2);
      mem_access(0, 3);
      wait_pc(32'h14, n);
      check("jr_cycles", n, 3);
      mem_access(0, 3);
      wait_pc(32'h1C, n);
      check("beq_fetch", n, 1);
      wait_pc(32'h18, n);
      check("beq_back", n, 2);

      // Program B: ALU coverage, r0 discard, branches, undefined op, reset mid-MEM.
      rst_n = 1'b0;
      for (int i = 0; i < 128; i++) imem[i] = 32'hFC00_0000;
      imem[0]  = i_i(T_ADDI, 0, 1, 5);
      imem[1]  = i_i(T_ADDI, 0, 6, -3);
      imem[2]  = r_i(F_SLT, 6, 1, 5, 0);
      imem[3]  = i_i(T_SLTI, 6, 7, -4);
      imem[4]  = r_i(F_NOR, 0, 0, 8, 0);
      imem[5]  = r_i(F_SLL, 0, 1, 9, 4);
      imem[6]  = r_i(F_SRL, 0, 8, 10, 28);
      imem[7]  = r_i(F_SUB, 1, 6, 11, 0);
      imem[8]  = i_i(T_ORI, 1, 12, 32'hF0);
      imem[9]  = i_i(T_ANDI, 8, 13, 32'hFF);
      imem[10] = r_i(F_AND, 9, 12, 14, 0);
      imem[11] = r_i(F_OR, 10, 9, 15, 0);
      imem[12] = i_i(T_ADDI, 0, 0, 7);
      imem[13] = i_i(T_ADDI, 8, 16, 2);
      for (int i = 0; i < 13; i++) begin
         imem[14 + i] = i_i(T_SW, 0, st_reg[i], 4 * i);
         exp_q.push_back(exp_st(i, st_val[i]));
      end
      imem[27] = i_i(T_BNE, 1, 1, 5);
      imem[28] = 32'hFC00_0000;
      imem[29] = i_i(T_BNE, 1, 0, 1);
      imem[30] = i_i(T_SW, 0, 1, 80);
      imem[31] = i_i(T_SW, 0, 1, 84);
      imem[32] = i_i(T_LW, 0, 17, 64);
      exp_q.push_back(exp_st(21, 32'd5));
      exp_q.push_back(exp_ld(16));

      do_reset();
      for (int i = 0; i < 13; i++) mem_access(0, (i == 0) ? 59 : 3);
      wait_pc(32'h74, n);
      check("bne_not_taken", n, 4);
      wait_pc(32'h78, n);
      check("undef_noop", n, 3);
      wait_pc(32'h7C, n);
      check("bne_taken", n, 2);
      mem_access(0, 3);
      mem_rdy = 1'b0;
      wait_cen(lat, exp);
      #2 rst_n = 1'b0;
      #1;
      check("abort_cen", {CEN, WEN, OEN}, 3'b111);
      check("abort_pc", IR_addr, 32'h0);
      check("abort_state", dbg_state, FETCH);

      // Program C: halt is absorbing.
      for (int i = 0; i < 128; i++) imem[i] = 32'hFC00_0000;
      imem[0] = i_i(T_ADDI, 0, 1, 1);
      imem[1] = 32'hFFFF_FFFF;
      imem[2] = i_i(T_SW, 0, 1, 0);
      @(negedge clk);
      do_reset();
      n = 0;
      while (halted !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("halt_cycles", n, 6);
      check("halt_state", dbg_state, HALT);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("halt_frozen", {IR_addr, CEN, halted}, {32'h8, 1'b1, 1'b1});
      end
      check("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
